// File: rtl/vme_cmd_arbiter_if.sv
// Bundle of requester-side and VME-master-side signals shared by the command arbiter.
// The arbiter uses the slave modport; a requester/VME model uses the master modport.
interface vme_cmd_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_rd;
    logic [16*NREQ-1:0] req_instr;
    logic [16*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]    ack;
    logic [15:0]        rsp_data;
    logic               rsp_err;
    logic               busy;
    logic [2:0]         grant_id;
    logic               vme_cmd_rd;
    logic               start;
    logic [31:0]        vme_cmd_reg;
    logic [31:0]        vme_dat_reg_in;
    logic [31:0]        vme_dat_reg_out;
    logic               vme_dat_wr;

    modport slave (
        input  req, req_rd, req_instr, req_wdata, vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
        output ack, rsp_data, rsp_err, busy, grant_id, start, vme_cmd_reg, vme_dat_reg_in
    );

    modport master (
        output req, req_rd, req_instr, req_wdata, vme_cmd_rd, vme_dat_reg_out, vme_dat_wr,
        input  ack, rsp_data, rsp_err, busy, grant_id, start, vme_cmd_reg, vme_dat_reg_in
    );
endinterface

// File: rtl/vme_cmd_arbiter.sv
// Round-robin arbiter that shares one VME command datapath between NREQ sources:
// grant, issue one command, wait for completion or timeout, then return ack/data/err.
module vme_cmd_arbiter #(
    parameter int          NREQ    = 4,
    parameter logic [31:0] MASK    = 32'h00a80000,
    parameter int          TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    vme_cmd_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [31:0]     din_q, din_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            busy_q, busy_d;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      ptr_q, ptr_d;
    logic            rd_q, rd_d;
    logic [9:0]      cnt_q, cnt_d;

    logic            found;
    int              sel_idx;
    logic            dat_hi_unused;

    logic [15:0]     instr_arr [NREQ];
    logic [15:0]     wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign instr_arr[gi] = bus.req_instr[16*gi +: 16];
        assign wdata_arr[gi] = bus.req_wdata[16*gi +: 16];
    end

    // Only the low half of the VME read word is returned to requesters.
    assign dat_hi_unused = ^bus.vme_dat_reg_out[31:16];

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        cmd_d      = cmd_q;
        din_d      = din_q;
        ack_d      = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = 1'b0;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        found      = 1'b0;
        sel_idx    = 0;

        // First requester at or after the pointer, wrapping around.
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % NREQ]) begin
                found   = 1'b1;
                sel_idx = (int'(ptr_q) + k) % NREQ;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found && bus.vme_cmd_rd) begin
                    state_d = S_ISSUE;
                    start_d = 1'b1;
                    grant_d = 3'(sel_idx);
                    rd_d    = bus.req_rd[sel_idx];
                    cmd_d   = MASK | {16'h0000, instr_arr[sel_idx]} |
                              (bus.req_rd[sel_idx] ? 32'h0200_0000 : 32'h0100_0000);
                    din_d   = bus.req_rd[sel_idx] ? 32'h0 : {16'h0000, wdata_arr[sel_idx]};
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 10'd1;
                if (bus.vme_dat_wr) begin
                    rsp_data_d = rd_q ? bus.vme_dat_reg_out[15:0] : 16'h0000;
                    state_d    = S_RESP;
                    for (int i = 0; i < NREQ; i++) ack_d[i] = (grant_q == 3'(i));
                end else if (cnt_q == 10'(TIMEOUT - 1)) begin
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                    for (int i = 0; i < NREQ; i++) ack_d[i] = (grant_q == 3'(i));
                end
            end
            S_RESP: begin
                ptr_d   = 3'((int'(grant_q) + 1) % NREQ);
                cmd_d   = MASK;
                din_d   = 32'h0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            cmd_q      <= MASK;
            din_q      <= 32'h0;
            ack_q      <= '0;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= 3'd0;
            ptr_q      <= 3'd0;
            rd_q       <= 1'b0;
            cnt_q      <= 10'd0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            cmd_q      <= cmd_d;
            din_q      <= din_d;
            ack_q      <= ack_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.start          = start_q;
    assign bus.vme_cmd_reg    = cmd_q;
    assign bus.vme_dat_reg_in = din_q;
    assign bus.ack            = ack_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.busy           = busy_q;
    assign bus.grant_id       = grant_q;
endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// Directed bench for vme_cmd_arbiter: table of single transactions plus hand-written
// sequences for round robin, timeout, back-pressure, stray strobes and reset in WAIT.
module tb_vme_cmd_arbiter;
    localparam logic [31:0] MASK = 32'h00a80000;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   model_ptr = 0;

    always #5 clk = ~clk;

    vme_cmd_arbiter_if #(.NREQ(4)) bus ();

    vme_cmd_arbiter #(.NREQ(4), .MASK(MASK), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          src;
        logic        rd;
        logic [15:0] instr;
        logic [15:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] exp_cmd;
        logic [31:0] exp_din;
        logic [3:0]  exp_ack;
        logic [15:0] exp_rsp;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            step();
            if (bus.start === 1'b1) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL start_wait: got no start expected start within 20 cycles");
        end
    endtask

    task automatic run_txn(input int src, input logic rd, input logic [15:0] instr,
                           input logic [15:0] wdata, input logic [31:0] rdata, input int dly,
                           input logic [31:0] exp_cmd, input logic [31:0] exp_din,
                           input logic [3:0] exp_ack, input logic [15:0] exp_rsp);
        bit ok;
        bus.req_rd[src]               = rd;
        bus.req_instr[16*src +: 16]   = instr;
        bus.req_wdata[16*src +: 16]   = wdata;
        bus.req[src]                  = 1'b1;
        wait_start(ok);
        if (ok) begin
            chk("cmd", bus.vme_cmd_reg, exp_cmd);
            chk("dat_in", bus.vme_dat_reg_in, exp_din);
            chk("grant_id", 32'(bus.grant_id), 32'(src));
            for (int c = 0; c < dly; c++) begin
                step();
                if (c == 0) chk("start_one_cycle", 32'(bus.start), 32'd0);
                chk("ack_early", 32'(bus.ack), 32'd0);
            end
            chk("cmd_hold", bus.vme_cmd_reg, exp_cmd);
            bus.vme_dat_reg_out = rdata;
            bus.vme_dat_wr      = 1'b1;
            step();
            bus.vme_dat_wr      = 1'b0;
            bus.req[src]        = 1'b0;
            chk("ack", 32'(bus.ack), 32'(exp_ack));
            chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp));
            chk("rsp_err", 32'(bus.rsp_err), 32'd0);
            step();
            chk("ack_one_cycle", 32'(bus.ack), 32'd0);
            chk("cmd_idle", bus.vme_cmd_reg, MASK);
            chk("dat_in_idle", bus.vme_dat_reg_in, 32'd0);
            chk("busy_idle", 32'(bus.busy), 32'd0);
            model_ptr = (src + 1) % 4;
        end
        $display("txn src=%0d rd=%0d instr=%h ack=%b rsp=%h", src, rd, instr, bus.ack, bus.rsp_data);
    endtask

    initial begin
        bit ok;
        int cnt;
        int g;

        vecs[0] = '{0, 1'b0, 16'h4100, 16'hBEEF, 32'h0,         3, 32'h01A84100, 32'h0000BEEF, 4'b0001, 16'h0000};
        vecs[1] = '{2, 1'b1, 16'h3000, 16'h7777, 32'h1234ABCD,  2, 32'h02A83000, 32'h00000000, 4'b0100, 16'hABCD};
        vecs[2] = '{1, 1'b0, 16'h00FF, 16'h0001, 32'hFFFF5555,  1, 32'h01A800FF, 32'h00000001, 4'b0010, 16'h0000};
        vecs[3] = '{3, 1'b1, 16'hFFFF, 16'h0000, 32'h00008001,  8, 32'h02A8FFFF, 32'h00000000, 4'b1000, 16'h8001};
        vecs[4] = '{0, 1'b1, 16'h1234, 16'h0000, 32'hABCD0000,  1, 32'h02A81234, 32'h00000000, 4'b0001, 16'h0000};

        rst_n               = 1'b0;
        bus.req             = '0;
        bus.req_rd          = '0;
        bus.req_instr       = '0;
        bus.req_wdata       = '0;
        bus.vme_cmd_rd      = 1'b1;
        bus.vme_dat_reg_out = '0;
        bus.vme_dat_wr      = 1'b0;
        step();
        step();
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_cmd", bus.vme_cmd_reg, MASK);
        chk("rst_dat_in", bus.vme_dat_reg_in, 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        $display("reset: cmd=%h busy=%0d", bus.vme_cmd_reg, bus.busy);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].src, vecs[v].rd, vecs[v].instr, vecs[v].wdata, vecs[v].rdata,
                    vecs[v].dly, vecs[v].exp_cmd, vecs[v].exp_din, vecs[v].exp_ack, vecs[v].exp_rsp);
        end

        // Round robin with all four sources requesting
        for (int i = 0; i < 4; i++) begin
            bus.req_rd[i]             = 1'b0;
            bus.req_instr[16*i +: 16] = 16'h0A00 + 16'(i);
            bus.req_wdata[16*i +: 16] = 16'h1000 + 16'(i);
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(ok);
            if (!ok) break;
            g = model_ptr;
            chk("rr_grant", 32'(bus.grant_id), 32'(g));
            chk("rr_cmd", bus.vme_cmd_reg, MASK | 32'h0100_0000 | (32'h0A00 + 32'(g)));
            step();
            bus.vme_dat_wr = 1'b1;
            step();
            bus.vme_dat_wr = 1'b0;
            chk("rr_ack", 32'(bus.ack), 32'd1 << g);
            $display("rr k=%0d grant=%0d ack=%b", k, bus.grant_id, bus.ack);
            bus.req[g] = 1'b0;
            step();
            bus.req[g] = 1'b1;
            model_ptr = (g + 1) % 4;
        end
        bus.req = '0;
        step();

        // Timeout: no completion strobe
        bus.req_rd[1]           = 1'b0;
        bus.req_instr[16 +: 16] = 16'h5555;
        bus.req[1]              = 1'b1;
        wait_start(ok);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            cnt++;
            if (bus.ack !== 4'b0000) break;
        end
        chk("to_latency", 32'(cnt), 32'd9);
        chk("to_ack", 32'(bus.ack), 32'b0010);
        chk("to_err", 32'(bus.rsp_err), 32'd1);
        chk("to_rsp", 32'(bus.rsp_data), 32'd0);
        $display("timeout: cycles=%0d ack=%b err=%0d", cnt, bus.ack, bus.rsp_err);
        bus.req[1] = 1'b0;
        step();
        chk("to_err_clear", 32'(bus.rsp_err), 32'd0);
        chk("to_ack_clear", 32'(bus.ack), 32'd0);
        model_ptr = 2;
        run_txn(3, 1'b1, 16'h0042, 16'h0, 32'h0000C0DE, 1, 32'h02A80042, 32'h0, 4'b1000, 16'hC0DE);

        // Back-pressure from vme_cmd_rd
        bus.vme_cmd_rd          = 1'b0;
        bus.req_rd[1]           = 1'b0;
        bus.req_instr[16 +: 16] = 16'h0777;
        bus.req_wdata[16 +: 16] = 16'h0999;
        bus.req                 = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_no_start", 32'(bus.start), 32'd0);
            chk("bp_no_busy", 32'(bus.busy), 32'd0);
        end
        bus.vme_cmd_rd = 1'b1;
        step();
        chk("bp_start", 32'(bus.start), 32'd1);
        chk("bp_grant", 32'(bus.grant_id), 32'd1);
        chk("bp_cmd", bus.vme_cmd_reg, 32'h01A80777);
        step();
        bus.vme_dat_wr = 1'b1;
        step();
        bus.vme_dat_wr = 1'b0;
        bus.req        = '0;
        chk("bp_ack", 32'(bus.ack), 32'b0010);
        $display("backpressure: ack=%b", bus.ack);
        step();

        // Stray completion strobe in IDLE
        bus.vme_dat_reg_out = 32'hFFFFFFFF;
        bus.vme_dat_wr      = 1'b1;
        step();
        chk("stray_ack", 32'(bus.ack), 32'd0);
        step();
        bus.vme_dat_wr = 1'b0;
        chk("stray_ack2", 32'(bus.ack), 32'd0);
        chk("stray_busy", 32'(bus.busy), 32'd0);
        $display("stray strobe: ack=%b busy=%0d", bus.ack, bus.busy);

        // Leave the pointer at 1 and rsp_data nonzero, then reset during WAIT
        run_txn(0, 1'b1, 16'h1111, 16'h0, 32'h00005A5A, 1, 32'h02A81111, 32'h0, 4'b0001, 16'h5A5A);
        bus.req_rd[2]           = 1'b0;
        bus.req_instr[32 +: 16] = 16'h2222;
        bus.req_wdata[32 +: 16] = 16'h3333;
        bus.req[2]              = 1'b1;
        wait_start(ok);
        step();
        step();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        bus.req = '0;
        chk("wrst_start", 32'(bus.start), 32'd0);
        chk("wrst_cmd", bus.vme_cmd_reg, MASK);
        chk("wrst_dat_in", bus.vme_dat_reg_in, 32'd0);
        chk("wrst_ack", 32'(bus.ack), 32'd0);
        chk("wrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("wrst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("wrst_busy", 32'(bus.busy), 32'd0);
        chk("wrst_grant", 32'(bus.grant_id), 32'd0);
        $display("reset in wait: busy=%0d grant=%0d", bus.busy, bus.grant_id);
        bus.vme_dat_wr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("wrst_no_ack", 32'(bus.ack), 32'd0);
        end
        bus.vme_dat_wr          = 1'b0;
        bus.req_rd[0]           = 1'b0;
        bus.req_instr[0 +: 16]  = 16'h0F0F;
        bus.req                 = 4'b0101;
        wait_start(ok);
        chk("post_rst_grant", 32'(bus.grant_id), 32'd0);
        chk("post_rst_cmd", bus.vme_cmd_reg, 32'h01A80F0F);
        step();
        bus.vme_dat_wr = 1'b1;
        step();
        bus.vme_dat_wr = 1'b0;
        bus.req        = '0;
        chk("post_rst_ack", 32'(bus.ack), 32'b0001);
        $display("post reset: ack=%b", bus.ack);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
